// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared types and constants for the two-byte instruction fetch sequencer.
// The ERR state exists only when FETCH_TIMEOUT_EN is defined.
package fetch_pkg;

  localparam int BYTE_W = 8;

  typedef logic [7:0] timeout_cnt_t;

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_LO = 3'd1,
    REQ_HI = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_LO = 2'd1,
    REQ_HI = 2'd2,
    DONE   = 2'd3
  } fetch_state_t;
`endif

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Fetch request, memory handshake and status signals of the fetch sequencer.
// The master modport is the sequencer side; slave is the controller/memory side.
interface instruction_fetch_sequencer_if;
  import fetch_pkg::*;

  logic              Start;
  logic [15:0]       Address;
  logic [15:0]       MemAddr;
  logic              MemReq;
  logic              MemRdy;
  logic [BYTE_W-1:0] MemData;
  logic              PcInc;
  logic [15:0]       IR;
  logic              Busy;
  logic              Done;
  logic              Error;

  modport master (
    input  Start, Address, MemRdy, MemData,
    output MemAddr, MemReq, PcInc, IR, Busy, Done, Error
  );

  modport slave (
    output Start, Address, MemRdy, MemData,
    input  MemAddr, MemReq, PcInc, IR, Busy, Done, Error
  );
endinterface

// File: rtl/instruction_fetch_sequencer_timeout.sv
// Per-byte wait counter; only instantiated when FETCH_TIMEOUT_EN is defined.
// expired is asserted in the wait cycle that would bring the count up to limit.
module fetch_timeout_counter
  import fetch_pkg::*;
(
  input  logic         Clock,
  input  logic         Reset,
  input  logic         clear,
  input  logic         enable,
  input  timeout_cnt_t limit,
  output logic         expired
);

  timeout_cnt_t count_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)      count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_q + 8'd1;
  end

  assign expired = enable && (count_q == limit - 8'd1);

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte instruction fetch: latches the PC, reads base and base+1 over a
// request/ready handshake, assembles IR. FETCH_TIMEOUT_EN adds a per-byte timeout.
module instruction_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  instruction_fetch_sequencer_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  fetch_state_t      state_q, state_d;
  logic [15:0]       base_q, base_d;
  logic [BYTE_W-1:0] shadow_q, shadow_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              pc_inc_q, pc_inc_d;
  logic [15:0]       ir_q, ir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef FETCH_TIMEOUT_EN
  logic error_q, error_d;
  logic cnt_clear, expired;

  assign cnt_clear = (state_d != state_q) && (state_d == REQ_LO || state_d == REQ_HI);

  fetch_timeout_counter u_timeout (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (cnt_clear),
    .enable  (mem_req_q && !bus.MemRdy),
    .limit   (timeout_cnt_t'(TIMEOUT_CYCLES)),
    .expired (expired)
  );
`endif

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    shadow_d   = shadow_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    pc_inc_d   = 1'b0;
    ir_d       = ir_q;
    done_d     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    error_d    = 1'b0;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          base_d     = bus.Address;
          mem_addr_d = bus.Address;
          mem_req_d  = 1'b1;
          state_d    = REQ_LO;
        end else begin
          state_d    = IDLE;
        end
      end
      REQ_LO: begin
        // base is used from here on: OutD lags the PC increment by a cycle.
        if (bus.MemRdy) begin
          shadow_d   = bus.MemData;
          mem_addr_d = base_q + 16'd1;
          pc_inc_d   = 1'b1;
          state_d    = REQ_HI;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (expired) begin
          mem_req_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ERR;
        end
`endif
      end
      REQ_HI: begin
        if (bus.MemRdy) begin
          ir_d      = {bus.MemData, shadow_q};
          mem_req_d = 1'b0;
          pc_inc_d  = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (expired) begin
          mem_req_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ERR;
        end
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == REQ_LO) || (state_d == REQ_HI);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      shadow_q   <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      pc_inc_q   <= 1'b0;
      ir_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      shadow_q   <= shadow_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      pc_inc_q   <= pc_inc_d;
      ir_q       <= ir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) error_q <= 1'b0;
    else        error_q <= error_d;
  end
  assign bus.Error = error_q;
`else
  assign bus.Error = 1'b0;
`endif

  assign bus.MemAddr = mem_addr_q;
  assign bus.MemReq  = mem_req_q;
  assign bus.PcInc   = pc_inc_q;
  assign bus.IR      = ir_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer: directed and random
// fetches against a byte-array memory model; timeout section needs FETCH_TIMEOUT_EN.
module tb_instruction_fetch_sequencer;

`ifdef FETCH_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  instruction_fetch_sequencer_if bus ();

  instruction_fetch_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int          checks = 0;
  int          errors = 0;
  int          wait_cycles = 0;
  bit          idle_noise = 1'b0;
  logic [15:0] prev_ir = 16'h0000;
  logic [7:0]  mem [logic [15:0]];

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: holds MemRdy low for wait_cycles cycles of each request, then
  // presents the byte; MemRdy may toggle randomly while no request is pending.
  bit fresh = 1'b1;
  int wait_left = 0;
  always @(negedge Clock) begin
    if (bus.MemReq !== 1'b1) begin
      fresh       = 1'b1;
      bus.MemRdy  = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.MemData = 8'($urandom);
    end else begin
      if (fresh) begin
        wait_left = wait_cycles;
        fresh     = 1'b0;
      end
      if (wait_left == 0) begin
        bus.MemRdy  = 1'b1;
        bus.MemData = mem_rd(bus.MemAddr);
        fresh       = 1'b1;
      end else begin
        bus.MemRdy  = 1'b0;
        bus.MemData = 8'($urandom);
        wait_left--;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, ".MemAddr"}, bus.MemAddr, 0);
    check({tag, ".MemReq"},  bus.MemReq,  0);
    check({tag, ".PcInc"},   bus.PcInc,   0);
    check({tag, ".IR"},      bus.IR,      0);
    check({tag, ".Busy"},    bus.Busy,    0);
    check({tag, ".Done"},    bus.Done,    0);
    check({tag, ".Error"},   bus.Error,   0);
  endtask

  // One fetch from base with 'waits' memory wait cycles per byte. Expected:
  // Done exactly 2+2*waits cycles after the Start-sampling edge, two PcInc
  // pulses, addresses base then base+1, IR = {mem[base+1], mem[base]}.
  task automatic run_fetch(input logic [15:0] base, input int waits, input bit poke_hi);
    logic [15:0] b1;
    logic [15:0] exp_ir;
    int k;
    int pc_cnt;
    bit poked;
    b1     = base + 16'd1;
    exp_ir = {mem_rd(b1), mem_rd(base)};
    k      = 0;
    pc_cnt = 0;
    poked  = 1'b0;
    wait_cycles = waits;
    @(negedge Clock);
    bus.Address = base;
    bus.Start   = 1'b1;
    @(negedge Clock);
    bus.Start   = 1'b0;
    bus.Address = 16'($urandom);
    while (bus.Done !== 1'b1 && k < 40) begin
      pc_cnt += int'(bus.PcInc);
      check("fetch.MemAddr", bus.MemAddr, (pc_cnt == 0) ? base : b1);
      check("fetch.MemReq",  bus.MemReq,  1);
      check("fetch.Busy",    bus.Busy,    1);
      check("fetch.IR_hold", bus.IR,      prev_ir);
      check("fetch.Error",   bus.Error,   0);
      if (poke_hi && pc_cnt > 0 && !poked) begin
        bus.Start = 1'b1;
        poked     = 1'b1;
      end
      @(negedge Clock);
      bus.Start   = 1'b0;
      bus.Address = 16'($urandom);
      k++;
    end
    pc_cnt += int'(bus.PcInc);
    check("fetch.Done",    bus.Done,   1);
    check("fetch.latency", k,          2 + 2 * waits);
    check("fetch.IR",      bus.IR,     exp_ir);
    check("fetch.PcIncs",  pc_cnt,     2);
    check("fetch.ReqOff",  bus.MemReq, 0);
    check("fetch.BusyOff", bus.Busy,   0);
    @(negedge Clock);
    check("post.Done",   bus.Done,   0);
    check("post.PcInc",  bus.PcInc,  0);
    check("post.MemReq", bus.MemReq, 0);
    check("post.IR",     bus.IR,     exp_ir);
    prev_ir = exp_ir;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ah [0:10];
    logic [15:0] b;
    bus.Start   = 1'b0;
    bus.Address = 16'h0000;
    mem[16'h0040] = 8'h34;
    mem[16'h0041] = 8'h12;

    // Reset state
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b1;

    // Zero-wait directed fetch, then wait states, wrap, and ignored Start in REQ_HI
    run_fetch(16'h0040, 0, 1'b0);
    check("directed.IR", bus.IR, 16'h1234);
    run_fetch(16'h1000, 3, 1'b0);
    run_fetch(16'hFFFF, 0, 1'b0);
    run_fetch(16'h2222, 2, 1'b1);

    // Back-to-back: Start held high, Address changing every cycle
    wait_cycles = 0;
    @(negedge Clock);
    ah[0] = 16'($urandom);
    bus.Address = ah[0];
    bus.Start   = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge Clock);
      check("b2b.Done",  bus.Done,  (k % 3 == 2) ? 1 : 0);
      check("b2b.PcInc", bus.PcInc, (k % 3 != 0) ? 1 : 0);
      check("b2b.Busy",  bus.Busy,  (k % 3 != 2) ? 1 : 0);
      if (k % 3 == 2) begin
        b = ah[k - 2];
        check("b2b.IR", bus.IR, {mem_rd(b + 16'd1), mem_rd(b)});
        prev_ir = {mem_rd(b + 16'd1), mem_rd(b)};
      end
      ah[k + 1]   = 16'($urandom);
      bus.Address = ah[k + 1];
    end
    bus.Start = 1'b0;
    @(negedge Clock);
    check("b2b.idle", bus.MemReq, 0);

    // Asynchronous reset in REQ_HI abandons the fetch
    wait_cycles = 3;
    @(negedge Clock);
    bus.Address = 16'h0300;
    bus.Start   = 1'b1;
    @(negedge Clock);
    bus.Start   = 1'b0;
    for (int k = 0; k < 20 && bus.PcInc !== 1'b1; k++) @(negedge Clock);
    check("rst.inHI", bus.PcInc, 1);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check("rst.noDone",  bus.Done,   0);
      check("rst.noPcInc", bus.PcInc,  0);
      check("rst.noReq",   bus.MemReq, 0);
      check("rst.IR",      bus.IR,     0);
    end
    prev_ir = 16'h0000;

`ifdef FETCH_TIMEOUT_EN
    // Timeout: MemRdy never rises for the low byte
    wait_cycles = 1000;
    @(negedge Clock);
    bus.Address = 16'h0500;
    bus.Start   = 1'b1;
    @(negedge Clock);
    bus.Start   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      check("to.Error", bus.Error, (k == TO) ? 1 : 0);
      check("to.PcInc", bus.PcInc, 0);
      check("to.IR",    bus.IR,    prev_ir);
      if (k >= TO) begin
        check("to.MemReq", bus.MemReq, 0);
        check("to.Busy",   bus.Busy,   0);
      end
    end
`endif

    // Random fetches against the memory model
    for (int n = 0; n < 16; n++) begin
      idle_noise = 1'($urandom_range(0, 1));
      run_fetch(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
